reservation_station_cdb: RTL

RESERVATION_STATION_CDB -- requirements
Module: reservation_station_cdb

---
 rtl/reservation_station_cdb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/reservation_station_cdb.sv
// rtl/reservation_station_cdb.sv - reservation station with CDB operand capture and oldest-first issue
// Age is kept as an older-than matrix so selection stays exact across arbitrary slot reuse.
module reservation_station_cdb #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int ROB_W = 3,
   parameter int OP_W  = 4,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int IW   = $clog2(DEPTH)
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             flush_in,
   input  logic             disp_valid_in,
   output logic             disp_ready_out,
   input  logic [OP_W-1:0]  disp_op_in,
   input  logic [ROB_W-1:0] disp_rob_idx_in,
   input  logic [XLEN-1:0]  disp_vi_in,
   input  logic [XLEN-1:0]  disp_vj_in,
   input  logic [ROB_W-1:0] disp_qi_in,
   input  logic [ROB_W-1:0] disp_qj_in,
   input  logic             disp_i_ready_in,
   input  logic             disp_j_ready_in,
   input  logic             cdb_valid_in,
   input  logic [ROB_W-1:0] cdb_tag_in,
   input  logic [XLEN-1:0]  cdb_data_in,
   output logic             iss_valid_out,
   input  logic             iss_ready_in,
   output logic [OP_W-1:0]  iss_op_out,
   output logic [ROB_W-1:0] iss_rob_idx_out,
   output logic [XLEN-1:0]  iss_vi_out,
   output logic [XLEN-1:0]  iss_vj_out,
   output logic [CW-1:0]    count_out
);

   logic [DEPTH-1:0] r_busy, r_ri, r_rj;
   logic [OP_W-1:0]  r_op    [DEPTH];
   logic [ROB_W-1:0] r_rob   [DEPTH];
   logic [XLEN-1:0]  r_vi    [DEPTH];
   logic [XLEN-1:0]  r_vj    [DEPTH];
   logic [ROB_W-1:0] r_qi    [DEPTH];
   logic [ROB_W-1:0] r_qj    [DEPTH];
   logic [DEPTH-1:0] r_older [DEPTH];
   logic [CW-1:0]    r_count;
   logic             r_iss_valid;
   logic [OP_W-1:0]  r_iss_op;
   logic [ROB_W-1:0] r_iss_rob;
   logic [XLEN-1:0]  r_iss_vi, r_iss_vj;

   logic [DEPTH-1:0] w_elig, w_pick;
   logic [IW-1:0]    w_sel_idx, w_free_idx;
   logic             w_any_elig, w_iss_load, w_disp_fire;
   logic             w_disp_ri, w_disp_rj;
   logic [XLEN-1:0]  w_disp_vi, w_disp_vj;

   // An entry is picked when no other eligible entry is older than it.
   always_comb begin
      w_elig = '0;
      w_pick = '0;
      w_sel_idx = '0;
      w_free_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_elig[i] = r_busy[i] & r_ri[i] & r_rj[i];
      end
      for (int i = 0; i < DEPTH; i++) begin
         w_pick[i] = w_elig[i] & ~|(w_elig & r_older[i]);
         if (w_pick[i]) w_sel_idx = IW'(i);
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_busy[i]) w_free_idx = IW'(i);
      end
   end

   assign w_any_elig  = |w_elig;
   assign w_iss_load  = w_any_elig & (~r_iss_valid | iss_ready_in);
   assign w_disp_fire = disp_valid_in & disp_ready_out & ~flush_in;
   assign w_disp_ri   = disp_i_ready_in | (cdb_valid_in & (disp_qi_in == cdb_tag_in));
   assign w_disp_rj   = disp_j_ready_in | (cdb_valid_in & (disp_qj_in == cdb_tag_in));
   assign w_disp_vi   = disp_i_ready_in ? disp_vi_in : cdb_data_in;
   assign w_disp_vj   = disp_j_ready_in ? disp_vj_in : cdb_data_in;

   assign disp_ready_out  = (r_count < CW'(DEPTH));
   assign count_out       = r_count;
   assign iss_valid_out   = r_iss_valid;
   assign iss_op_out      = r_iss_op;
   assign iss_rob_idx_out = r_iss_rob;
   assign iss_vi_out      = r_iss_vi;
   assign iss_vj_out      = r_iss_vj;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_busy      <= '0;
         r_count     <= '0;
         r_iss_valid <= 1'b0;
      end else if (flush_in) begin
         r_busy      <= '0;
         r_count     <= '0;
         r_iss_valid <= 1'b0;
      end else begin
         if (w_iss_load) begin
            r_busy[w_sel_idx] <= 1'b0;
            r_iss_valid       <= 1'b1;
         end else if (iss_ready_in) begin
            r_iss_valid <= 1'b0;
         end
         if (w_disp_fire) r_busy[w_free_idx] <= 1'b1;
         r_count <= r_count + CW'(w_disp_fire) - CW'(w_iss_load);
      end
   end

   // Payload, ready bits and age rows only matter while busy, so they carry no reset.
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (cdb_valid_in && r_busy[i] && !r_ri[i] && (r_qi[i] == cdb_tag_in)) begin
            r_vi[i] <= cdb_data_in;
            r_ri[i] <= 1'b1;
         end
         if (cdb_valid_in && r_busy[i] && !r_rj[i] && (r_qj[i] == cdb_tag_in)) begin
            r_vj[i] <= cdb_data_in;
            r_rj[i] <= 1'b1;
         end
      end
      if (w_iss_load) begin
         r_iss_op  <= r_op[w_sel_idx];
         r_iss_rob <= r_rob[w_sel_idx];
         r_iss_vi  <= r_vi[w_sel_idx];
         r_iss_vj  <= r_vj[w_sel_idx];
      end
      if (w_disp_fire) begin
         r_op[w_free_idx]  <= disp_op_in;
         r_rob[w_free_idx] <= disp_rob_idx_in;
         r_vi[w_free_idx]  <= w_disp_vi;
         r_vj[w_free_idx]  <= w_disp_vj;
         r_qi[w_free_idx]  <= disp_qi_in;
         r_qj[w_free_idx]  <= disp_qj_in;
         r_ri[w_free_idx]  <= w_disp_ri;
         r_rj[w_free_idx]  <= w_disp_rj;
         for (int j = 0; j < DEPTH; j++) begin
            r_older[j][w_free_idx] <= 1'b0;
         end
         r_older[w_free_idx] <= r_busy;
      end
   end

endmodule
